// File: rtl/score_keeper.sv
// score_keeper
//
// Purpose:
//   Game-side score engine feeding the end-of-game score overlay. Point
//   awards are accumulated into a 3-digit packed-BCD working score that
//   saturates at 999. The score is added one digit per cycle. The displayed
//   score is copied from the working score only on frame boundaries (falling
//   edge of v_sync), so the overlay never tears mid-frame. A session high
//   score is also tracked.
//
// Ports:
//   i_clk          system/pixel clock, rising-edge logic
//   i_rst          synchronous active-high reset
//   i_v_sync       VGA vertical sync, active low; frame boundary = falling edge
//   i_game_start   one-cycle pulse: begin a new game
//   i_game_over    one-cycle pulse: game finished
//   i_point_valid  point award request
//   i_point_value  points to add (0-15, clamped to MAX_DIGIT)
//   o_point_ready  award accepted when valid && ready
//   o_score_value  displayed score, packed BCD {hundreds,tens,ones}
//   o_high_score   session high score, packed BCD
//   o_is_end       end-of-game display enable for the overlay
//   o_new_high     final score beat the previous high score

module score_keeper #(
  parameter logic [3:0] MAX_DIGIT = 4'd9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_game_start,
  input  logic        i_game_over,
  input  logic        i_point_valid,
  input  logic [3:0]  i_point_value,
  output logic        o_point_ready,
  output logic [11:0] o_score_value,
  output logic [11:0] o_high_score,
  output logic        o_is_end,
  output logic        o_new_high
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAYING,
    S_ADD0,
    S_ADD1,
    S_ADD2,
    S_WAIT_END,
    S_ENDED
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_ready;

  logic        r_prevVsync;
  logic        w_fb;

  logic [11:0] r_work;
  logic [7:0]  r_accLow;
  logic [3:0]  r_addend;
  logic        r_carry;
  logic        r_pendEnd;

  logic [11:0] r_score;
  logic [11:0] r_high;
  logic        r_isEnd;
  logic        r_newHigh;

  logic [3:0]  w_clamped;
  logic [3:0]  w_digIn;
  logic [3:0]  w_addend;
  logic        w_carryIn;
  logic [4:0]  w_digSum;
  logic [3:0]  w_digOut;
  logic        w_carryOut;

  assign w_fb      = r_prevVsync & ~i_v_sync;
  assign w_clamped = (i_point_value > MAX_DIGIT) ? MAX_DIGIT : i_point_value;

  assign o_point_ready = w_ready;
  assign o_score_value = r_score;
  assign o_high_score  = r_high;
  assign o_is_end      = r_isEnd;
  assign o_new_high    = r_newHigh;

  // State register for the game/adder FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the ready handshake. Awards are only taken in
  // PLAYING; the three ADD states walk the digits ones -> tens -> hundreds.
  // A game-over seen during the final digit still has to divert to WAIT_END,
  // so it is ORed with the pending flag rather than waiting for it to land.
  always_comb begin
    w_stateNext = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_game_start) w_stateNext = S_PLAYING;
      end
      S_PLAYING: begin
        w_ready = 1'b1;
        if (i_point_valid)    w_stateNext = S_ADD0;
        else if (i_game_over) w_stateNext = S_WAIT_END;
      end
      S_ADD0: w_stateNext = S_ADD1;
      S_ADD1: w_stateNext = S_ADD2;
      S_ADD2: begin
        w_stateNext = (r_pendEnd | i_game_over) ? S_WAIT_END : S_PLAYING;
      end
      S_WAIT_END: begin
        if (w_fb) w_stateNext = S_ENDED;
      end
      S_ENDED: begin
        if (i_game_start) w_stateNext = S_PLAYING;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Single shared BCD digit adder. Only the ones digit gets the award; the
  // upper digits just absorb the ripple carry. For sums 10..19 the corrected
  // digit s-10 equals the low nibble of s plus 6, modulo 16.
  always_comb begin
    w_digIn    = 4'd0;
    w_addend   = 4'd0;
    w_carryIn  = 1'b0;
    case (r_state)
      S_ADD0: begin
        w_digIn  = r_work[3:0];
        w_addend = r_addend;
      end
      S_ADD1: begin
        w_digIn   = r_work[7:4];
        w_carryIn = r_carry;
      end
      S_ADD2: begin
        w_digIn   = r_work[11:8];
        w_carryIn = r_carry;
      end
      default: ;
    endcase
    w_digSum   = {1'b0, w_digIn} + {1'b0, w_addend} + {4'd0, w_carryIn};
    w_digOut   = w_digSum[3:0];
    w_carryOut = 1'b0;
    if (w_digSum > 5'd9) begin
      w_digOut   = w_digSum[3:0] + 4'd6;
      w_carryOut = 1'b1;
    end
  end

  // Score datapath. New digits collect in r_accLow and the working score is
  // committed in one go at the end of ADD2, so a frame boundary during an add
  // always publishes the pre-add value and never a half-updated one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prevVsync <= 1'b1;
      r_work      <= 12'h000;
      r_accLow    <= 8'h00;
      r_addend    <= 4'd0;
      r_carry     <= 1'b0;
      r_pendEnd   <= 1'b0;
      r_score     <= 12'h000;
      r_high      <= 12'h000;
      r_isEnd     <= 1'b0;
      r_newHigh   <= 1'b0;
    end else begin
      r_prevVsync <= i_v_sync;
      case (r_state)
        S_IDLE: begin
          if (i_game_start) r_work <= 12'h000;
        end
        S_PLAYING: begin
          if (i_point_valid) begin
            r_addend  <= w_clamped;
            r_pendEnd <= i_game_over;
          end
          if (w_fb) r_score <= r_work;
        end
        S_ADD0: begin
          r_accLow[3:0] <= w_digOut;
          r_carry       <= w_carryOut;
          if (i_game_over) r_pendEnd <= 1'b1;
          if (w_fb) r_score <= r_work;
        end
        S_ADD1: begin
          r_accLow[7:4] <= w_digOut;
          r_carry       <= w_carryOut;
          if (i_game_over) r_pendEnd <= 1'b1;
          if (w_fb) r_score <= r_work;
        end
        S_ADD2: begin
          r_work    <= w_carryOut ? 12'h999 : {w_digOut, r_accLow};
          r_pendEnd <= 1'b0;
          if (w_fb) r_score <= r_work;
        end
        S_WAIT_END: begin
          if (w_fb) begin
            r_score <= r_work;
            r_isEnd <= 1'b1;
            if (r_work > r_high) begin
              r_high    <= r_work;
              r_newHigh <= 1'b1;
            end else begin
              r_newHigh <= 1'b0;
            end
          end
        end
        S_ENDED: begin
          if (i_game_start) begin
            r_work    <= 12'h000;
            r_isEnd   <= 1'b0;
            r_newHigh <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
